// File: rtl/dma_mc_pkg.sv
// Shared types and constants for the multi-channel DMA core.
// Optional build macro: DMA_AUTOINIT_EN widens the mode register to 4 bits (bit3 = autoinit).
package dma_mc_pkg;

  // Service FSM: idle, hold request, address/dack phase, strobe phase.
  typedef enum logic [1:0] {
    StSi = 2'd0,
    StS0 = 2'd1,
    StS1 = 2'd2,
    StS2 = 2'd3
  } dma_state_e;

  // cfg_sel codes
  localparam logic [2:0] CfgBaseAddr = 3'd0;
  localparam logic [2:0] CfgBaseCnt  = 3'd1;
  localparam logic [2:0] CfgMode     = 3'd2;
  localparam logic [2:0] CfgMask     = 3'd3;
  localparam logic [2:0] CfgCmd      = 3'd4;

  // Mode register bit positions
  localparam int unsigned ModeDir   = 0;  // 0: mem_wr, 1: mem_rd
  localparam int unsigned ModeDec   = 1;  // 0: +1, 1: -1
  localparam int unsigned ModeBlock = 2;  // 0: single, 1: block
`ifdef DMA_AUTOINIT_EN
  localparam int unsigned ModeAutoinit = 3;
  localparam int unsigned ModeW        = 4;
`else
  localparam int unsigned ModeW        = 3;
`endif

  // Command register bit positions
  localparam int unsigned CmdDisable = 0;
  localparam int unsigned CmdRotate  = 1;
  localparam int unsigned CmdW       = 2;

  // Per-channel control state that does not depend on the address/count widths.
  typedef struct packed {
    logic [ModeW-1:0] mode;
    logic             mask;
  } ch_ctrl_t;

endpackage

// File: rtl/dma_mc_arbiter.sv
// Priority encoder for pending DMA requests, fixed or rotating, plus the rotate pointer.
// Ports:
//   CLK, RESET  - clock, synchronous active-high reset
//   req         - pending request vector (dreq & ~mask)
//   rotate      - 1: search starts at the rotate pointer, 0: lowest index wins
//   advance     - pulse when a service of served_ch completes
//   served_ch   - channel whose service just completed
//   grant_valid - some request is pending
//   grant_ch    - winning channel index
module dma_mc_arbiter
  import dma_mc_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      rotate,
  input  logic                      advance,
  input  logic [$clog2(NUM_CH)-1:0] served_ch,
  output logic                      grant_valid,
  output logic [$clog2(NUM_CH)-1:0] grant_ch
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  logic [ChW-1:0] ptr_q, ptr_d;
  logic [ChW-1:0] start;
  int             idx;

  // Walk the search order backwards so the last hit (first in order) wins.
  always_comb begin
    start       = rotate ? ptr_q : '0;
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % int'(NUM_CH);
      if (req[ChW'(idx)]) begin
        grant_valid = 1'b1;
        grant_ch    = ChW'(idx);
      end
    end
  end

  // The pointer tracks completed services in both modes so that enabling rotation
  // later starts just after the most recently served channel.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (32'(served_ch) == NUM_CH - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = served_ch + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dma_multi_channel_core.sv
// Parametrised 8237-style multi-channel DMA controller core.
// Holds per-channel base/current address and count, mode and mask, the global command
// register, and the SI->S0->S1->S2 service FSM with HRQ/HLDA handshake.
// Optional build macro: DMA_AUTOINIT_EN (autoinit reload on terminal count).
// Ports:
//   CLK, RESET   - clock, synchronous active-high reset
//   cfg_we       - configuration write strobe
//   cfg_ch       - target channel
//   cfg_sel      - 0 base addr, 1 base count, 2 mode, 3 mask (bit0), 4 command
//   cfg_wdata    - write data
//   dreq         - per-channel level request
//   hrq / hlda   - bus hold request / acknowledge
//   dack         - one-hot channel acknowledge (S1/S2)
//   addr         - transfer address (S1/S2, else 0)
//   mem_rd/wr    - one-cycle memory strobe in S2
//   tc           - terminal count pulse
//   busy         - FSM not idle
module dma_multi_channel_core
  import dma_mc_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic                                         cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]                    cfg_ch,
  input  logic [2:0]                                   cfg_sel,
  input  logic [((ADDR_W > CNT_W) ? ADDR_W : CNT_W)-1:0] cfg_wdata,
  input  logic [NUM_CH-1:0]                            dreq,
  output logic                                         hrq,
  input  logic                                         hlda,
  output logic [NUM_CH-1:0]                            dack,
  output logic [ADDR_W-1:0]                            addr,
  output logic                                         mem_rd,
  output logic                                         mem_wr,
  output logic                                         tc,
  output logic                                         busy
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  dma_state_e      state_q, state_d;
  logic [ChW-1:0]  ch_q, ch_d;
  logic [CmdW-1:0] cmd_q;

  logic [ADDR_W-1:0] base_addr_q [NUM_CH];
  logic [ADDR_W-1:0] cur_addr_q  [NUM_CH];
  logic [CNT_W-1:0]  base_cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt_q   [NUM_CH];
  ch_ctrl_t          ctrl_q      [NUM_CH];

  logic [NUM_CH-1:0] pending;
  logic              grant_valid;
  logic [ChW-1:0]    grant_ch;
  logic              advance;

  logic              cfg_ok;
  logic              cfg_hit_active;
  logic [ADDR_W-1:0] act_addr, step_addr;
  logic [CNT_W-1:0]  act_cnt, dec_cnt;
  ch_ctrl_t          act_ctrl;
  logic              is_tc;
  logic              autoinit;

  always_comb begin
    pending = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      pending[i] = dreq[i] & ~ctrl_q[i].mask;
    end
  end

  dma_mc_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arbiter (
    .CLK         (CLK),
    .RESET       (RESET),
    .req         (pending),
    .rotate      (cmd_q[CmdRotate]),
    .advance     (advance),
    .served_ch   (ch_q),
    .grant_valid (grant_valid),
    .grant_ch    (grant_ch)
  );

  // Values of the channel currently latched by the FSM.
  always_comb begin
    act_addr  = cur_addr_q[ch_q];
    act_cnt   = cur_cnt_q[ch_q];
    act_ctrl  = ctrl_q[ch_q];
    step_addr = act_ctrl.mode[ModeDec] ? act_addr - 1'b1 : act_addr + 1'b1;
    dec_cnt   = act_cnt - 1'b1;
    // Count 0 at S2 means this is the last transfer (the decrement wraps to all-ones).
    is_tc     = (act_cnt == '0);
`ifdef DMA_AUTOINIT_EN
    autoinit  = act_ctrl.mode[ModeAutoinit];
`else
    autoinit  = 1'b0;
`endif
  end

  // Channel registers of the channel in its address/strobe phase are write-protected.
  assign cfg_ok         = (32'(cfg_ch) < NUM_CH);
  assign cfg_hit_active = ((state_q == StS1) || (state_q == StS2)) && (cfg_ch == ch_q);

  // FSM next state
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    advance = 1'b0;
    case (state_q)
      StSi: begin
        if (grant_valid && !cmd_q[CmdDisable]) begin
          ch_d    = grant_ch;
          state_d = StS0;
        end
      end
      StS0: begin
        if (!pending[ch_q]) begin
          state_d = StSi;
        end else if (hlda) begin
          state_d = StS1;
        end
      end
      StS1: begin
        // Once in S1 the transfer always finishes its strobe, even if hlda drops.
        state_d = StS2;
      end
      StS2: begin
        if (is_tc || !act_ctrl.mode[ModeBlock] || !hlda) begin
          state_d = StSi;
          advance = 1'b1;
        end else begin
          state_d = StS1;
        end
      end
      default: state_d = StSi;
    endcase
  end

  // Outputs decode purely from registered state.
  always_comb begin
    hrq    = (state_q != StSi);
    busy   = (state_q != StSi);
    dack   = '0;
    addr   = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    tc     = 1'b0;
    if ((state_q == StS1) || (state_q == StS2)) begin
      dack[ch_q] = 1'b1;
      addr       = act_addr;
    end
    if (state_q == StS2) begin
      mem_rd = act_ctrl.mode[ModeDir];
      mem_wr = ~act_ctrl.mode[ModeDir];
      tc     = is_tc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StSi;
      ch_q    <= '0;
      cmd_q   <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        base_addr_q[i] <= '0;
        cur_addr_q[i]  <= '0;
        base_cnt_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
        ctrl_q[i]      <= '{mode: '0, mask: 1'b1};
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;

      if (cfg_we) begin
        if (cfg_sel == CfgCmd) begin
          cmd_q <= cfg_wdata[CmdW-1:0];
        end else if (cfg_ok && !cfg_hit_active) begin
          case (cfg_sel)
            CfgBaseAddr: begin
              base_addr_q[cfg_ch] <= cfg_wdata[ADDR_W-1:0];
              cur_addr_q[cfg_ch]  <= cfg_wdata[ADDR_W-1:0];
            end
            CfgBaseCnt: begin
              base_cnt_q[cfg_ch] <= cfg_wdata[CNT_W-1:0];
              cur_cnt_q[cfg_ch]  <= cfg_wdata[CNT_W-1:0];
            end
            CfgMode: ctrl_q[cfg_ch].mode <= cfg_wdata[ModeW-1:0];
            CfgMask: ctrl_q[cfg_ch].mask <= cfg_wdata[0];
            default: ;
          endcase
        end
      end

      // End of a strobe cycle: advance the active channel.
      if (state_q == StS2) begin
        if (is_tc && autoinit) begin
          cur_addr_q[ch_q] <= base_addr_q[ch_q];
          cur_cnt_q[ch_q]  <= base_cnt_q[ch_q];
        end else begin
          cur_addr_q[ch_q] <= step_addr;
          cur_cnt_q[ch_q]  <= dec_cnt;
        end
        if (is_tc && !autoinit) begin
          ctrl_q[ch_q].mask <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_multi_channel_core.sv
// Directed self-checking bench for dma_multi_channel_core (default parameters).
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_dma_multi_channel_core;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [2:0]  cfg_sel;
  logic [15:0] cfg_wdata;
  logic [3:0]  dreq;
  logic        hrq;
  logic        hlda;
  logic [3:0]  dack;
  logic [15:0] addr;
  logic        mem_rd;
  logic        mem_wr;
  logic        tc;
  logic        busy;

  int errors = 0;
  int checks = 0;

  dma_multi_channel_core #(
    .NUM_CH (4),
    .ADDR_W (16),
    .CNT_W  (16)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .dreq      (dreq),
    .hrq       (hrq),
    .hlda      (hlda),
    .dack      (dack),
    .addr      (addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .tc        (tc),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // {hrq, busy, dack, addr, mem_rd, mem_wr, tc}
  function automatic logic [24:0] outs();
    return {hrq, busy, dack, addr, mem_rd, mem_wr, tc};
  endfunction

  function automatic logic [24:0] pack(input logic h, input logic [3:0] d, input logic [15:0] a,
                                       input logic rd, input logic wr, input logic t);
    return {h, h, d, a, rd, wr, t};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    dreq  = '0;
    hlda  = 1'b0;
    cfg_we = 1'b0;
    step();
    RESET = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [1:0] ch, input logic [15:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_ch    = ch;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic setup_ch(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] cnt,
                          input logic [15:0] mode);
    cfg_write(3'd0, ch, a);
    cfg_write(3'd1, ch, cnt);
    cfg_write(3'd2, ch, mode);
    cfg_write(3'd3, ch, 16'h0000);
  endtask

  // Steps until a strobe is seen or the limit expires; returns what was on the bus then.
  task automatic wait_strobe(input int limit, output int cycles, output logic [15:0] a,
                             output logic t, output logic rd, output logic wr,
                             output logic [3:0] dk);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!(mem_rd | mem_wr) && cycles < limit);
    a  = addr;
    t  = tc;
    rd = mem_rd;
    wr = mem_wr;
    dk = dack;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (outs() !== 25'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0", outs());
    end
    // Every channel starts masked, so requests must be ignored.
    dreq = 4'b1111;
    hlda = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (hrq !== 1'b0) begin
        errors++;
        $display("FAIL reset_masked_hrq: got %b expected 0 (cycle %0d)", hrq, c);
      end
    end
    dreq = '0;
  endtask

  task automatic test_single_mode();
    int          cyc;
    logic [15:0] a;
    logic        t, rd, wr;
    logic [3:0]  dk;
    do_reset();
    setup_ch(2'd1, 16'h1000, 16'd2, 16'h0001);  // single, increment, mem_rd
    hlda = 1'b1;
    dreq = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(20, cyc, a, t, rd, wr, dk);
      checks++;
      if (cyc !== 3) begin
        errors++;
        $display("FAIL single_latency%0d: got %0d cycles expected 3", k, cyc);
      end
      checks++;
      if ({rd, wr} !== 2'b10) begin
        errors++;
        $display("FAIL single_strobe%0d: got rd/wr %b expected 10", k, {rd, wr});
      end
      checks++;
      if (a !== 16'h1000 + 16'(k)) begin
        errors++;
        $display("FAIL single_addr%0d: got %h expected %h", k, a, 16'h1000 + 16'(k));
      end
      checks++;
      if (dk !== 4'b0010) begin
        errors++;
        $display("FAIL single_dack%0d: got %b expected 0010", k, dk);
      end
      checks++;
      if (t !== (k == 2)) begin
        errors++;
        $display("FAIL single_tc%0d: got %b expected %b", k, t, (k == 2));
      end
      // Back-to-back services must be separated by an idle cycle with hrq low.
      step();
      checks++;
      if ({hrq, busy, dack} !== 6'b0) begin
        errors++;
        $display("FAIL single_gap%0d: got %b expected 000000", k, {hrq, busy, dack});
      end
    end
    // Channel 1 is masked after TC; dreq is still high.
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (hrq !== 1'b0) begin
      errors++;
      $display("FAIL single_mask_after_tc: got hrq %b expected 0", hrq);
    end
    dreq = '0;
  endtask

  task automatic test_block_decrement();
    logic [24:0] exp [6];
    do_reset();
    setup_ch(2'd0, 16'h00FF, 16'd1, 16'h0006);  // block, decrement, mem_wr
    exp[0] = pack(1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    exp[1] = pack(1'b1, 4'b0001, 16'h00FF, 1'b0, 1'b0, 1'b0);
    exp[2] = pack(1'b1, 4'b0001, 16'h00FF, 1'b0, 1'b1, 1'b0);
    exp[3] = pack(1'b1, 4'b0001, 16'h00FE, 1'b0, 1'b0, 1'b0);
    exp[4] = pack(1'b1, 4'b0001, 16'h00FE, 1'b0, 1'b1, 1'b1);
    exp[5] = pack(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    hlda = 1'b1;
    dreq = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (outs() !== exp[c]) begin
        errors++;
        $display("FAIL block_cycle%0d: got %h expected %h", c, outs(), exp[c]);
      end
      // Block mode keeps going once started, whatever dreq does.
      if (c == 1) dreq = 4'b0000;
    end
  endtask

  task automatic test_fixed_priority();
    int          cyc;
    logic [15:0] a;
    logic        t, rd, wr;
    logic [3:0]  dk;
    do_reset();
    setup_ch(2'd1, 16'h0100, 16'd5, 16'h0001);
    setup_ch(2'd3, 16'h0300, 16'd5, 16'h0001);
    hlda = 1'b1;
    dreq = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      wait_strobe(20, cyc, a, t, rd, wr, dk);
      checks++;
      if ({dk, a} !== {4'b0010, 16'h0100 + 16'(k)}) begin
        errors++;
        $display("FAIL fixed_prio%0d: got dack %b addr %h expected dack 0010 addr %h",
                 k, dk, a, 16'h0100 + 16'(k));
      end
    end
    dreq = '0;
  endtask

  task automatic test_rotating_priority();
    int          cyc;
    logic [15:0] a;
    logic        t, rd, wr;
    logic [3:0]  dk;
    logic [3:0]  exp_dk [3];
    logic [15:0] exp_a  [3];
    exp_dk[0] = 4'b0010; exp_a[0] = 16'h0100;
    exp_dk[1] = 4'b1000; exp_a[1] = 16'h0300;
    exp_dk[2] = 4'b0010; exp_a[2] = 16'h0101;
    do_reset();
    cfg_write(3'd4, 2'd0, 16'h0002);
    setup_ch(2'd1, 16'h0100, 16'd5, 16'h0001);
    setup_ch(2'd3, 16'h0300, 16'd5, 16'h0001);
    hlda = 1'b1;
    dreq = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(20, cyc, a, t, rd, wr, dk);
      checks++;
      if ({dk, a} !== {exp_dk[k], exp_a[k]}) begin
        errors++;
        $display("FAIL rotate_prio%0d: got dack %b addr %h expected dack %b addr %h",
                 k, dk, a, exp_dk[k], exp_a[k]);
      end
    end
    dreq = '0;
  endtask

  task automatic test_disable();
    int          cyc;
    logic [15:0] a;
    logic        t, rd, wr;
    logic [3:0]  dk;
    do_reset();
    setup_ch(2'd0, 16'h0040, 16'd0, 16'h0001);
    cfg_write(3'd4, 2'd0, 16'h0001);
    hlda = 1'b1;
    dreq = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (hrq !== 1'b0) begin
        errors++;
        $display("FAIL disable_hrq%0d: got %b expected 0", c, hrq);
      end
    end
    cfg_write(3'd4, 2'd0, 16'h0000);
    wait_strobe(20, cyc, a, t, rd, wr, dk);
    checks++;
    if ({dk, a, t} !== {4'b0001, 16'h0040, 1'b1}) begin
      errors++;
      $display("FAIL disable_release: got dack %b addr %h tc %b expected 0001 0040 1", dk, a, t);
    end
    dreq = '0;
  endtask

  task automatic test_hlda_handshake();
    int          cyc;
    logic [15:0] a;
    logic        t, rd, wr;
    logic [3:0]  dk;
    do_reset();
    setup_ch(2'd2, 16'h0200, 16'd0, 16'h0001);
    hlda = 1'b0;
    dreq = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if ({hrq, dack} !== 5'b10000) begin
        errors++;
        $display("FAIL hlda_wait%0d: got hrq/dack %b expected 10000", c, {hrq, dack});
      end
    end
    hlda = 1'b1;
    wait_strobe(20, cyc, a, t, rd, wr, dk);
    checks++;
    if ({cyc[3:0], dk, a, t} !== {4'd2, 4'b0100, 16'h0200, 1'b1}) begin
      errors++;
      $display("FAIL hlda_grant: got cyc %0d dack %b addr %h tc %b expected 2 0100 0200 1",
               cyc, dk, a, t);
    end

    // Request withdrawn while waiting for hlda.
    do_reset();
    setup_ch(2'd2, 16'h0200, 16'd0, 16'h0001);
    hlda = 1'b0;
    dreq = 4'b0100;
    step();
    step();
    checks++;
    if (hrq !== 1'b1) begin
      errors++;
      $display("FAIL drop_hrq_before: got %b expected 1", hrq);
    end
    dreq = 4'b0000;
    step();
    checks++;
    if ({hrq, busy, dack} !== 6'b0) begin
      errors++;
      $display("FAIL drop_return_idle: got %b expected 000000", {hrq, busy, dack});
    end
  endtask

  task automatic test_reset_in_s2();
    int          cyc;
    logic [15:0] a;
    logic        t, rd, wr;
    logic [3:0]  dk;
    do_reset();
    setup_ch(2'd0, 16'h0010, 16'd5, 16'h0006);
    hlda = 1'b1;
    dreq = 4'b0001;
    wait_strobe(20, cyc, a, t, rd, wr, dk);
    checks++;
    if ({wr, a} !== {1'b1, 16'h0010}) begin
      errors++;
      $display("FAIL rst_s2_reach: got wr %b addr %h expected 1 0010", wr, a);
    end
    RESET = 1'b1;
    step();
    checks++;
    if (outs() !== 25'h0) begin
      errors++;
      $display("FAIL rst_s2_outputs: got %0h expected 0", outs());
    end
    RESET = 1'b0;
    dreq  = 4'b1111;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (hrq !== 1'b0) begin
      errors++;
      $display("FAIL rst_s2_masks: got hrq %b expected 0", hrq);
    end
    dreq = '0;
  endtask

`ifdef DMA_AUTOINIT_EN
  task automatic test_autoinit();
    int          cyc;
    logic [15:0] a;
    logic        t, rd, wr;
    logic [3:0]  dk;
    do_reset();
    setup_ch(2'd2, 16'h0400, 16'd0, 16'h0009);  // autoinit, single, mem_rd
    hlda = 1'b1;
    dreq = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      wait_strobe(20, cyc, a, t, rd, wr, dk);
      checks++;
      if ({rd, dk, a, t} !== {1'b1, 4'b0100, 16'h0400, 1'b1}) begin
        errors++;
        $display("FAIL autoinit%0d: got rd %b dack %b addr %h tc %b expected 1 0100 0400 1",
                 k, rd, dk, a, t);
      end
    end
    dreq = '0;
  endtask
`endif

  initial begin
    RESET     = 1'b1;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_sel   = '0;
    cfg_wdata = '0;
    dreq      = '0;
    hlda      = 1'b0;
    step();
    test_reset();
    test_single_mode();
    test_block_decrement();
    test_fixed_priority();
    test_rotating_priority();
    test_disable();
    test_hlda_handshake();
    test_reset_in_s2();
`ifdef DMA_AUTOINIT_EN
    test_autoinit();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
